// File: rtl/hist_pkg.sv
// Shared constants, FSM state encoding and the saturating bin increment
// for the histogram arbiter.
package hist_pkg;

    localparam int BIN_W   = 8;
    localparam int CNT_W   = 11;
    localparam int NBINS   = 256;
    localparam int WIN_LEN = 1024;
    localparam int WIN_W   = $clog2(WIN_LEN);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [BIN_W-1:0] CLR_LAST = BIN_W'(NBINS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        HRD  = 3'd3,
        CLR  = 3'd4
    } state_t;

    // A bin never needs to hold more than one full window; stick at the top.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Single-port bin memory: NBINS x CNT_W, one-cycle synchronous read,
// write-enable. Read data shows the old contents on a write cycle.
module hist_bin_ram
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic [BIN_W-1:0] addr,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] mem [NBINS];

    // Write when enabled; always register the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hist_arb.sv
// Histogram arbiter: shares one bin RAM between sample read-modify-writes,
// host bin reads and a full clear sweep, tracking the running mode and a
// per-window mode snapshot.
// Handshake: a sample moves when in_valid && in_ready at a rising edge;
// in_ready never depends on in_valid. host_req is a level held until the
// one-cycle host_ack; host_count is valid only while host_ack is high.
// Build option: define HIST_AUTO_CLEAR_EN to start a clear sweep at each
// window end; otherwise the block stalls samples until clr_req.
module hist_arb
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] in_data,
    output logic             in_ready,
    input  logic             host_req,
    input  logic [BIN_W-1:0] host_bin,
    output logic             host_ack,
    output logic [CNT_W-1:0] host_count,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic [BIN_W-1:0] mode_data,
    output logic [CNT_W-1:0] mode_count,
    output logic             win_done,
    output logic [BIN_W-1:0] win_mode_data,
    output logic [CNT_W-1:0] win_mode_count,
    output state_t           dbg_state
);

`ifdef HIST_AUTO_CLEAR_EN
    localparam bit AUTO_CLR = 1'b1;
`else
    localparam bit AUTO_CLR = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [BIN_W-1:0] clr_addr_q, sample_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             pend_q, host_turn_q, full_q, host_ack_q, win_done_q;
    logic [BIN_W-1:0] mode_data_q, win_data_q;
    logic [CNT_W-1:0] mode_cnt_q, win_cnt_val_q;

    logic [BIN_W-1:0] ram_addr;
    logic             ram_we;
    logic [CNT_W-1:0] ram_wdata, ram_rdata, new_cnt;

    logic dec_pt, host_ok, host_first, win_end, clr_go, stall, mode_win;

    hist_bin_ram u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Decision terms shared by next-state and in_ready. The ack cycle masks
    // host_req so a still-held request is not served twice.
    assign dec_pt     = (state_q == IDLE) || (state_q == WR);
    assign host_ok    = host_req && !host_ack_q;
    assign host_first = host_ok && host_turn_q;
    assign win_end    = (state_q == WR) && (win_cnt_q == WIN_LAST);
    assign clr_go     = pend_q || clr_req || (win_end && AUTO_CLR);
    assign stall      = full_q || (win_end && !AUTO_CLR);
    assign new_cnt    = sat_inc(ram_rdata);
    assign mode_win   = new_cnt > mode_cnt_q;

    // State register; reset lands in the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear > host (its turn) > sample > host.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WR: begin
                if (clr_go)                  state_d = CLR;
                else if (host_first)         state_d = HRD;
                else if (in_valid && !stall) state_d = RD;
                else if (host_ok)            state_d = HRD;
                else                         state_d = IDLE;
            end
            RD:      state_d = WR;
            HRD:     state_d = IDLE;
            CLR:     state_d = (clr_addr_q == CLR_LAST) ? IDLE : CLR;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM: RAM port control and sample acceptance.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            RD:  ram_addr = sample_q;
            WR: begin
                ram_addr  = sample_q;
                ram_we    = 1'b1;
                ram_wdata = new_cnt;
            end
            HRD: ram_addr = host_bin;
            CLR: begin
                ram_addr = clr_addr_q;
                ram_we   = 1'b1;
            end
            default: ram_addr = '0;
        endcase
        in_ready = dec_pt && !clr_go && !host_first && !stall;
    end

    // Datapath: mode tracking, window accounting, host ack, clear bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr_q    <= '0;
            sample_q      <= '0;
            win_cnt_q     <= '0;
            pend_q        <= 1'b0;
            host_turn_q   <= 1'b0;
            full_q        <= 1'b0;
            host_ack_q    <= 1'b0;
            win_done_q    <= 1'b0;
            mode_data_q   <= '0;
            mode_cnt_q    <= '0;
            win_data_q    <= '0;
            win_cnt_val_q <= '0;
        end else begin
            host_ack_q <= (state_q == HRD);
            win_done_q <= 1'b0;
            if (in_valid && in_ready) begin
                sample_q <= in_data;
            end
            if (state_q == WR) begin
                host_turn_q <= 1'b1;
            end else if (state_q == HRD) begin
                host_turn_q <= 1'b0;
            end
            if (clr_req && state_q != CLR) begin
                pend_q <= 1'b1;
            end
            if (state_q == WR) begin
                if (mode_win) begin
                    mode_data_q <= sample_q;
                    mode_cnt_q  <= new_cnt;
                end
                if (win_end) begin
                    win_cnt_q     <= '0;
                    win_done_q    <= 1'b1;
                    win_data_q    <= mode_win ? sample_q : mode_data_q;
                    win_cnt_val_q <= mode_win ? new_cnt : mode_cnt_q;
                    if (AUTO_CLR) pend_q <= 1'b1;
                    else          full_q <= 1'b1;
                end else begin
                    win_cnt_q <= win_cnt_q + 1'b1;
                end
            end
            if (state_q == CLR) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
            // Entering the sweep wipes the running statistics last so it
            // overrides any update from the final write.
            if (state_d == CLR && state_q != CLR) begin
                clr_addr_q  <= '0;
                win_cnt_q   <= '0;
                pend_q      <= 1'b0;
                full_q      <= 1'b0;
                mode_data_q <= '0;
                mode_cnt_q  <= '0;
            end
        end
    end

    assign host_ack       = host_ack_q;
    assign host_count     = host_ack_q ? ram_rdata : '0;
    assign clr_busy       = (state_q == CLR);
    assign mode_data      = mode_data_q;
    assign mode_count     = mode_cnt_q;
    assign win_done       = win_done_q;
    assign win_mode_data  = win_data_q;
    assign win_mode_count = win_cnt_val_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/hist_arb.md
HIST_ARB -- requirements
Module: hist_arb

Interface
REQ-001 The module SHALL have these ports: clk, input, 1, single clock, all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid/in_data  input  1/8  sample stream; a sample is accepted when in_valid&in_ready at a rising edge.
REQ-004 in_ready  output  1  sample accept enable, combinational from state.
REQ-005 host_req/host_bin  input  1/8  level read request for one bin, held until host_ack.
REQ-006 host_ack/host_count  output  1/11  one-cycle read response and bin count.
REQ-007 clr_req  input  1  one-cycle clear request.
REQ-008 clr_busy  output  1  high while the clear sweep runs.
REQ-009 mode_data/mode_count  output  8/11  live most-frequent value and its count.
REQ-010 win_done  output  1  one-cycle pulse after the 1024th sample of a window is written.
REQ-011 win_mode_data/win_mode_count  output  8/11  mode latched at window end.

Function
REQ-012 The block SHALL arbitrate one single-port, synchronous-read 256x11 bin RAM between sample increments, host reads and clear.
REQ-013 FSM states SHALL be IDLE, RD, WR, HRD, CLR.
- RD: RAM addr=sample, read.
- WR: write read+1.
- HRD: RAM addr=host_bin.
- CLR: write 0 at addr 0..255, one per cycle.
REQ-014 Decision points SHALL be IDLE and WR; priority: pending clear > host when host_turn=1 > sample > host.
REQ-015 in_ready SHALL be 1 only in IDLE or WR when the decision would grant the sample; back-to-back throughput is 1 sample per 2 cycles.
REQ-016 host_turn SHALL set on every WR and clear on every HRD, so a held host_req is served within 4 cycles under a continuous stream.
REQ-017 host_ack/host_count SHALL be registered and valid exactly in the cycle after HRD; host_req is ignored in that ack cycle.
REQ-018 mode_data/mode_count SHALL update at the WR edge only when the new count is strictly greater than mode_count; ties keep the current mode.
REQ-019 Counts SHALL be 11 bits; 1024 is the maximum and SHALL NOT overflow.
REQ-020 A window sample counter SHALL count WR cycles.
- On the 1024th: win_done pulses the next cycle, win_mode_* latch the post-update mode, and the counter goes to 0.
REQ-021 clr_req arriving in RD/WR SHALL latch pending; the RMW completes, then CLR is entered. clr_req during CLR SHALL be ignored.
REQ-022 On CLR entry, mode_data, mode_count and the window counter SHALL go to 0; CLR lasts exactly 256 cycles, then IDLE.
REQ-023 In CLR, in_ready SHALL be 0 and host_req SHALL be held off.

Reset
REQ-024 rst SHALL force state CLR at sweep address 0, clr_busy=1, and all other outputs and the pending, host_turn and window counter to 0.
REQ-025 rst asserted mid-operation SHALL abort any RMW or host read with no host_ack; bins are reinitialised by the sweep.

Configuration
REQ-026 With HIST_AUTO_CLEAR_EN defined, window end SHALL set clear pending, so CLR follows that WR automatically.
REQ-027 Without HIST_AUTO_CLEAR_EN, window end SHALL set a full flag.
- While full: in_ready=0 and host reads are still served.
- clr_req clears full via CLR.

Structure
REQ-028 Package hist_pkg SHALL hold BIN_W=8, CNT_W=11, NBINS=256, WIN_LEN=1024 and the state enum.
REQ-029 The RAM SHALL be sub-module hist_bin_ram: 256x11, single port, 1-cycle synchronous read, write-enable.

Verification
REQ-030 Reset release -> clr_busy=1 for 256 cycles with in_ready=0; then a read of 0x55 -> host_count=0.
REQ-031 Stream 0x10 x5 then 0x20 x3, continuous in_valid.
- in_ready accepts every 2nd cycle.
- mode=0x10/5.
- Host read of 0x20 -> 3.
REQ-032 Stream 0x30, 0x40, 0x40, 0x30 -> mode 0x30/1, 0x30/1, 0x40/2, 0x40/2 (tie kept).
REQ-033 host_req held during a continuous stream -> host_ack within 4 cycles; the stream resumes alternating.
REQ-034 1024 samples of 0xFF -> single win_done, win_mode=0xFF/1024.
- EN: then clr_busy for 256 cycles.
- no EN: in_ready stays 0 until clr_req.
REQ-035 clr_req in an RD cycle for sample 0x22 -> the WR completes, then CLR; a later read of 0x22 -> 0.
